// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl
//   Left-to-right square-and-multiply sequencer that computes
//   result = x^e mod m. It drives one Montgomery multiplier through its
//   start/done handshake.
//   Op sequence: xt = MM(x, r2); A = r; for each used exponent bit, MSB first:
//   A = MM(A, A), and A = MM(A, xt) when the bit is 1; finally A = MM(A, 1).
// Ports
//   clk, resetn               clock, synchronous active-low reset
//   start                     request pulse, accepted only while idle
//   in_x, in_e, e_len         base, exponent, number of exponent bits used
//   in_m, in_r, in_r2         odd modulus, R mod m, R^2 mod m
//   mm_a, mm_b, mm_m          multiplier operands, held for the whole op
//   mm_start                  one-cycle multiplier launch
//   mm_result, mm_done        multiplier product and completion strobe
//   busy, done, result        status, completion pulse, final value
module mont_exp_ctrl #(
    parameter int WIDTH     = 1024,
    parameter int EXP_WIDTH = 1024,
    parameter int LEN_W     = 11
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [LEN_W-1:0]     e_len,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_r,
    input  logic [WIDTH-1:0]     in_r2,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_m,
    output logic                 mm_start,
    input  logic [WIDTH-1:0]     mm_result,
    input  logic                 mm_done,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_PRE    = 4'd1,
        S_PRE_W  = 4'd2,
        S_SQ     = 4'd3,
        S_SQ_W   = 4'd4,
        S_MUL    = 4'd5,
        S_MUL_W  = 4'd6,
        S_POST   = 4'd7,
        S_POST_W = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(EXP_WIDTH);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    // Plain integer one: MM(A, 1) converts A out of the Montgomery domain.
    localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

    state_t                 state_r;
    state_t                 state_next_s;
    logic [WIDTH-1:0]       x_r;
    logic [EXP_WIDTH-1:0]   e_r;
    logic [LEN_W-1:0]       len_r;
    logic [LEN_W-1:0]       idx_r;
    logic [WIDTH-1:0]       m_r;
    logic [WIDTH-1:0]       r_r;
    logic [WIDTH-1:0]       r2_r;
    logic [WIDTH-1:0]       xt_r;
    logic [WIDTH-1:0]       acc_r;
    logic [WIDTH-1:0]       mm_a_r;
    logic [WIDTH-1:0]       mm_b_r;
    logic [WIDTH-1:0]       mm_m_r;
    logic                   mm_start_r;
    logic                   busy_r;
    logic                   done_r;
    logic [WIDTH-1:0]       result_r;
    logic [LEN_W-1:0]       len_clamp_s;
    logic [EXP_WIDTH-1:0]   e_shift_s;
    logic                   e_bit_s;
    logic                   last_bit_s;

    // Exponent lengths beyond the register width are limited to the register width.
    always_comb begin
        len_clamp_s = e_len;
        if (e_len > MAX_LEN) begin
            len_clamp_s = MAX_LEN;
        end else begin
            len_clamp_s = e_len;
        end
    end

    // Current exponent bit and last-bit flag. A shift is used so the index width
    // need not match the exponent width exactly.
    always_comb begin
        e_shift_s  = e_r >> idx_r;
        e_bit_s    = e_shift_s[0];
        last_bit_s = (idx_r == LEN_ZERO);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic. mm_done counts only in the *_W states.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = S_PRE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_PRE:  state_next_s = S_PRE_W;
            S_PRE_W: begin
                if (!mm_done) begin
                    state_next_s = S_PRE_W;
                end else if (len_r == LEN_ZERO) begin
                    state_next_s = S_POST;
                end else begin
                    state_next_s = S_SQ;
                end
            end
            S_SQ:   state_next_s = S_SQ_W;
            S_SQ_W: begin
                if (!mm_done) begin
                    state_next_s = S_SQ_W;
                end else if (e_bit_s) begin
                    state_next_s = S_MUL;
                end else if (last_bit_s) begin
                    state_next_s = S_POST;
                end else begin
                    state_next_s = S_SQ;
                end
            end
            S_MUL:  state_next_s = S_MUL_W;
            S_MUL_W: begin
                if (!mm_done) begin
                    state_next_s = S_MUL_W;
                end else if (last_bit_s) begin
                    state_next_s = S_POST;
                end else begin
                    state_next_s = S_SQ;
                end
            end
            S_POST: state_next_s = S_POST_W;
            S_POST_W: begin
                if (mm_done) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_POST_W;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Datapath: operand capture, launches, result capture and status flags.
    // Launch states load operands and raise mm_start for the next cycle only.
    // The operands then stay put until the following launch.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_r        <= W_ZERO;
            e_r        <= {EXP_WIDTH{1'b0}};
            len_r      <= LEN_ZERO;
            idx_r      <= LEN_ZERO;
            m_r        <= W_ZERO;
            r_r        <= W_ZERO;
            r2_r       <= W_ZERO;
            xt_r       <= W_ZERO;
            acc_r      <= W_ZERO;
            mm_a_r     <= W_ZERO;
            mm_b_r     <= W_ZERO;
            mm_m_r     <= W_ZERO;
            mm_start_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= W_ZERO;
        end else begin
            mm_start_r <= 1'b0;
            done_r     <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        x_r    <= in_x;
                        e_r    <= in_e;
                        len_r  <= len_clamp_s;
                        m_r    <= in_m;
                        r_r    <= in_r;
                        r2_r   <= in_r2;
                        busy_r <= 1'b1;
                    end
                end
                S_PRE: begin
                    mm_a_r     <= x_r;
                    mm_b_r     <= r2_r;
                    mm_m_r     <= m_r;
                    mm_start_r <= 1'b1;
                end
                S_PRE_W: begin
                    if (mm_done) begin
                        xt_r  <= mm_result;
                        acc_r <= r_r;
                        idx_r <= len_r - LEN_ONE;
                    end
                end
                S_SQ: begin
                    mm_a_r     <= acc_r;
                    mm_b_r     <= acc_r;
                    mm_m_r     <= m_r;
                    mm_start_r <= 1'b1;
                end
                S_SQ_W: begin
                    if (mm_done) begin
                        acc_r <= mm_result;
                        // With a 1 bit the index moves on after the multiply.
                        if (!e_bit_s && !last_bit_s) begin
                            idx_r <= idx_r - LEN_ONE;
                        end
                    end
                end
                S_MUL: begin
                    mm_a_r     <= acc_r;
                    mm_b_r     <= xt_r;
                    mm_m_r     <= m_r;
                    mm_start_r <= 1'b1;
                end
                S_MUL_W: begin
                    if (mm_done) begin
                        acc_r <= mm_result;
                        if (!last_bit_s) begin
                            idx_r <= idx_r - LEN_ONE;
                        end
                    end
                end
                S_POST: begin
                    mm_a_r     <= acc_r;
                    mm_b_r     <= W_ONE;
                    mm_m_r     <= m_r;
                    mm_start_r <= 1'b1;
                end
                S_POST_W: begin
                    if (mm_done) begin
                        acc_r <= mm_result;
                    end
                end
                S_DONE: begin
                    result_r <= acc_r;
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign mm_a     = mm_a_r;
    assign mm_b     = mm_b_r;
    assign mm_m     = mm_m_r;
    assign mm_start = mm_start_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl at WIDTH = EXP_WIDTH = 16.
// A behavioural Montgomery multiplier with programmable latency answers the
// controller. The expected results come from plain modular exponentiation.
module tb_mont_exp_ctrl;

    localparam int W  = 16;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  in_x = '0;
    logic [W-1:0]  in_e = '0;
    logic [LW-1:0] e_len = '0;
    logic [W-1:0]  in_m = '0;
    logic [W-1:0]  in_r = '0;
    logic [W-1:0]  in_r2 = '0;
    logic [W-1:0]  mm_a, mm_b, mm_m, mm_result, result;
    logic          mm_start, mm_done, busy, done;
    logic          stray_done = 1'b0;

    mont_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(W), .LEN_W(LW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_e(in_e), .e_len(e_len), .in_m(in_m),
        .in_r(in_r), .in_r2(in_r2),
        .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m), .mm_start(mm_start),
        .mm_result(mm_result), .mm_done(mm_done),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // a*b*2^-16 mod m by bit-serial halving
    function automatic logic [W-1:0] mont(input logic [W-1:0] a, b, m);
        logic [47:0] t;
        t = 48'(a) * 48'(b);
        for (int k = 0; k < W; k++) begin
            if (t[0]) t = t + 48'(m);
            t = t >> 1;
        end
        return W'(t % 48'(m));
    endfunction

    function automatic int clamp_len(input int len);
        return (len > W) ? W : len;
    endfunction

    // Right-to-left binary exponentiation over the low len bits.
    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] x, e, input int len, input logic [W-1:0] m);
        logic [63:0] acc, base;
        int l;
        l = clamp_len(len);
        acc = 64'd1 % 64'(m);
        base = 64'(x) % 64'(m);
        for (int k = 0; k < l; k++) begin
            if (e[k]) acc = (acc * base) % 64'(m);
            base = (base * base) % 64'(m);
        end
        return W'(acc);
    endfunction

    function automatic int ref_ops(input logic [W-1:0] e, input int len);
        int c, l;
        l = clamp_len(len);
        c = 2 + l;
        for (int k = 0; k < l; k++) if (e[k]) c++;
        return c;
    endfunction

    // Multiplier model: done is visible lat_cfg cycles after the start-sampling edge.
    int           lat_cfg = 1;
    logic         mdl_done = 1'b0;
    logic [W-1:0] mdl_res = '0;
    logic         mdl_pend = 1'b0;
    int           mdl_cnt = 0;
    always @(posedge clk) begin
        if (!resetn) begin
            mdl_done <= 1'b0;
            mdl_pend <= 1'b0;
            mdl_cnt  <= 0;
        end else begin
            mdl_done <= 1'b0;
            if (mm_start) begin
                mdl_res <= mont(mm_a, mm_b, mm_m);
                if (lat_cfg <= 1) begin
                    mdl_done <= 1'b1;
                    mdl_pend <= 1'b0;
                end else begin
                    mdl_pend <= 1'b1;
                    mdl_cnt  <= lat_cfg - 1;
                end
            end else if (mdl_pend) begin
                if (mdl_cnt <= 1) begin
                    mdl_done <= 1'b1;
                    mdl_pend <= 1'b0;
                end else begin
                    mdl_cnt <= mdl_cnt - 1;
                end
            end
        end
    end
    assign mm_result = mdl_res;
    assign mm_done   = mdl_done | stray_done;

    // Handshake monitor: counts launches and done pulses. It flags operand changes
    // while an op is outstanding, and any overlapping launches.
    int           start_cnt = 0;
    int           done_cnt = 0;
    int           viol = 0;
    logic         outst = 1'b0;
    logic [W-1:0] sa = '0, sb = '0, sm = '0;
    always @(posedge clk) begin
        if (mm_start) start_cnt <= start_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (!resetn) begin
            outst <= 1'b0;
        end else if (mm_start) begin
            if (outst) viol <= viol + 1;
            outst <= 1'b1;
            sa <= mm_a; sb <= mm_b; sm <= mm_m;
        end else if (outst) begin
            if (mm_a !== sa || mm_b !== sb || mm_m !== sm) viol <= viol + 1;
            if (mm_done) outst <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive_req(input logic [W-1:0] x, e, input logic [LW-1:0] len, input logic [W-1:0] m);
        logic [63:0] r64, r2_64;
        r64   = (64'd1 << W) % 64'(m);
        r2_64 = (64'd1 << (2 * W)) % 64'(m);
        in_x = x; in_e = e; e_len = len; in_m = m;
        in_r = W'(r64); in_r2 = W'(r2_64);
    endtask

    task automatic scramble_inputs();
        in_x = W'($urandom); in_e = W'($urandom); e_len = LW'($urandom);
        in_m = W'($urandom); in_r = W'($urandom); in_r2 = W'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_starts(input int base, input int cnt);
        int n;
        n = 0;
        while ((start_cnt - base) < cnt && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [W-1:0] x, e, input logic [LW-1:0] len,
                           input logic [W-1:0] m, input int lat, input logic [W-1:0] exp_res, input int exp_ops);
        int s0, v0, d0, n;
        lat_cfg = lat;
        drive_req(x, e, len, m);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s0 = start_cnt; v0 = viol; d0 = done_cnt;
        check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
        scramble_inputs();
        wait_done(n);
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_ops"}, 32'(start_cnt - s0), 32'(exp_ops));
        check({tag, "_latency"}, 32'(n + 1), 32'(exp_ops * (2 + lat) + 2));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_result_hold"}, 32'(result), 32'(exp_res));
        check({tag, "_operands_stable"}, 32'(viol - v0), 32'd0);
        check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    endtask

    typedef struct {
        logic [W-1:0]  x;
        logic [W-1:0]  e;
        logic [LW-1:0] len;
        logic [W-1:0]  m;
        int            lat;
        logic [W-1:0]  res;
        int            ops;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int s1, d1, n;
        logic [W-1:0] rx, re, rm;
        int rl, rlat;

        tbl[0] = '{x: 16'd2, e: 16'h0011, len: 5'd5,  m: 16'h00F1, lat: 1,  res: 16'h00D1, ops: 9};
        tbl[1] = '{x: 16'd2, e: 16'h0011, len: 5'd5,  m: 16'h00F1, lat: 40, res: 16'h00D1, ops: 9};
        tbl[2] = '{x: 16'd3, e: 16'h00FF, len: 5'd8,  m: 16'h00F1, lat: 3,  res: 16'h0008, ops: 18};
        tbl[3] = '{x: 16'd5, e: 16'h0000, len: 5'd0,  m: 16'h00F1, lat: 2,  res: 16'h0001, ops: 2};
        tbl[4] = '{x: 16'd2, e: 16'h0001, len: 5'd31, m: 16'h00F1, lat: 2,  res: 16'h0002, ops: 19};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mm_start", 32'(mm_start), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_mm_a", 32'(mm_a), 32'd0);
        check("rst_mm_b", 32'(mm_b), 32'd0);
        check("rst_mm_m", 32'(mm_m), 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i].x, tbl[i].e, tbl[i].len, tbl[i].m,
                    tbl[i].lat, tbl[i].res, tbl[i].ops);
        end

        // start during SQ_W, then a stray mm_done while idle
        lat_cfg = 10;
        drive_req(16'd2, 16'h0011, 5'd5, 16'h00F1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s1 = start_cnt; d1 = done_cnt;
        wait_starts(s1, 2);
        repeat (3) @(posedge clk);
        #1;
        drive_req(16'd7, 16'h00FF, 5'd8, 16'h00F1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        check("midstart_done_seen", 32'(done), 32'd1);
        check("midstart_result", 32'(result), 32'h00D1);
        check("midstart_ops", 32'(start_cnt - s1), 32'd9);
        @(posedge clk); #1;
        stray_done = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("stray_no_op", 32'(start_cnt - s1), 32'd9);
        check("stray_single_done", 32'(done_cnt - d1), 32'd1);
        check("stray_result", 32'(result), 32'h00D1);
        check("stray_busy", 32'(busy), 32'd0);

        // one-cycle reset while SQ_W is waiting
        lat_cfg = 10;
        drive_req(16'd2, 16'h0011, 5'd5, 16'h00F1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s1 = start_cnt;
        wait_starts(s1, 2);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_mm_start", 32'(mm_start), 32'd0);
        s1 = start_cnt; d1 = done_cnt;
        repeat (50) @(posedge clk);
        #1;
        check("abort_no_launch", 32'(start_cnt - s1), 32'd0);
        check("abort_no_done", 32'(done_cnt - d1), 32'd0);
        run_vec("rerun", 16'd2, 16'h0011, 5'd5, 16'h00F1, 4, 16'h00D1, 9);

        // random operands against the reference model
        for (int i = 0; i < 12; i++) begin
            rm   = W'($urandom_range(1, 32767) * 2 + 1);
            rx   = W'($urandom_range(0, int'(rm) - 1));
            re   = W'($urandom);
            rl   = $urandom_range(0, 20);
            rlat = $urandom_range(1, 6);
            run_vec($sformatf("rnd%0d", i), rx, re, LW'(rl), rm, rlat,
                    ref_modexp(rx, re, rl, rm), ref_ops(re, rl));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
